// File: rtl/serial_gate_unit_pkg.sv
// Shared definitions for the bit-serial gate unit.
// Holds the gate opcode encodings, the FSM state encoding and a helper that
// classifies an opcode as legal or illegal.
package serial_gate_unit_pkg;

    // Gate opcodes; values above OP_LAST are illegal.
    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NOR  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_LAST = 3'd5;

    // FSM state encoding.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    function automatic logic op_legal(input logic [2:0] op);
        return (op <= OP_LAST);
    endfunction

endpackage

// File: rtl/serial_gate_unit_if.sv
// Handshake/bus bundle for serial_gate_unit.
// Signals:
//   in_valid/in_ready   operand handshake (producer -> unit)
//   op, a, b            opcode and WIDTH-bit operands
//   out_valid/out_ready result handshake (unit -> consumer)
//   result, zero, err   WIDTH-bit result and status flags
//   busy                unit is in SHIFT or DONE
// Modports: master = environment side, slave = unit side.
interface serial_gate_unit_if #(
    parameter int unsigned WIDTH = 8
) ();

    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             err;
    logic             busy;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, zero, err, busy
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, zero, err, busy
    );

endinterface

// File: rtl/serial_gate_unit_gate_slice.sv
// Combinational 1-bit gate slice.
// Evaluates all six two-input gate primitives on (a_i, b_i) and selects one
// by op_i. Illegal opcodes yield 0.
// Ports:
//   a_i, b_i  operand bits
//   op_i      gate select
//   y_o       selected gate output
module serial_gate_unit_gate_slice
    import serial_gate_unit_pkg::*;
(
    input  logic       a_i,
    input  logic       b_i,
    input  logic [2:0] op_i,
    output logic       y_o
);

    logic and_w;
    logic or_w;
    logic nor_w;
    logic nand_w;
    logic xor_w;
    logic xnor_w;

    // Built-in gate primitives only accept positional terminals (out, in, in).
    and  u_and  (and_w,  a_i, b_i);
    or   u_or   (or_w,   a_i, b_i);
    nor  u_nor  (nor_w,  a_i, b_i);
    nand u_nand (nand_w, a_i, b_i);
    xor  u_xor  (xor_w,  a_i, b_i);
    xnor u_xnor (xnor_w, a_i, b_i);

    always_comb begin
        y_o = 1'b0;
        case (op_i)
            OP_AND:  y_o = and_w;
            OP_OR:   y_o = or_w;
            OP_NOR:  y_o = nor_w;
            OP_NAND: y_o = nand_w;
            OP_XOR:  y_o = xor_w;
            OP_XNOR: y_o = xnor_w;
            default: y_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/serial_gate_unit.sv
// Bit-serial logic unit.
// Accepts two WIDTH-bit operands and a gate opcode, evaluates the gate one
// bit per cycle (LSB first) through a single 1-bit slice, and returns the
// WIDTH-bit result over an output handshake.
// Ports:
//   clk  clock, all state updates on the rising edge
//   rst  synchronous active-high reset
//   bus  slave side of serial_gate_unit_if (handshakes, operands, result, flags)
module serial_gate_unit
    import serial_gate_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input logic               clk,
    input logic               rst,
    serial_gate_unit_if.slave bus
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [2:0]       op_q, op_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             slice_y;

    serial_gate_unit_gate_slice u_slice (
        .a_i  (a_sh_q[0]),
        .b_i  (b_sh_q[0]),
        .op_i (op_q),
        .y_o  (slice_y)
    );

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    a_sh_d = bus.a;
                    b_sh_d = bus.b;
                    op_d   = bus.op;
                    cnt_d  = '0;
                    res_d  = '0;
                    if (op_legal(bus.op)) begin
                        err_d   = 1'b0;
                        state_d = ST_SHIFT;
                    end else begin
                        // Illegal op skips the datapath; result stays cleared.
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                // Bits enter at the MSB so that after WIDTH shifts bit 0 of
                // the operands lands in bit 0 of the result.
                res_d  = {slice_y, res_q[WIDTH-1:1]};
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                if (cnt_q == CntLast) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        bus.in_ready  = (state_q == ST_IDLE);
        bus.out_valid = (state_q == ST_DONE);
        bus.busy      = (state_q != ST_IDLE);
        bus.result    = res_q;
        bus.err       = err_q;
        // Qualified by DONE so the flag reads 0 out of reset and while idle.
        bus.zero      = (state_q == ST_DONE) && !err_q && !(|res_q);
    end

endmodule

// File: tb/tb_serial_gate_unit.sv
// Directed self-checking bench for serial_gate_unit (WIDTH = 8).
module tb_serial_gate_unit;

    localparam int unsigned W = 8;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   lat;
    int   seen;

    serial_gate_unit_if #(.WIDTH(W)) bus ();

    serial_gate_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called from IDLE, #1 after an edge. Returns the cycle index (1 = cycle
    // right after the accept edge) in which out_valid is first seen.
    task automatic xact(input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv,
                        output int l);
        bus.op       = o;
        bus.a        = av;
        bus.b        = bv;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        l = 1;
        while (!bus.out_valid && l < 40) begin
            step();
            l++;
        end
    endtask

    task automatic finish_xact(input string tag);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check({tag, ".out_valid_drop"}, {31'd0, bus.out_valid}, 32'd0);
        check({tag, ".in_ready_back"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op        = 3'd0;
        bus.a         = 8'h00;
        bus.b         = 8'h00;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst.in_ready",  {31'd0, bus.in_ready},  32'd1);
        check("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst.result",    {24'd0, bus.result},    32'h00);
        check("rst.zero",      {31'd0, bus.zero},      32'd0);
        check("rst.err",       {31'd0, bus.err},       32'd0);
        check("rst.busy",      {31'd0, bus.busy},      32'd0);

        // AND timing with out_ready held high
        bus.out_ready = 1'b1;
        xact(3'd0, 8'hF0, 8'hCC, lat);
        check("and.latency", lat, 32'd9);
        check("and.result", {24'd0, bus.result}, 32'hC0);
        check("and.zero", {31'd0, bus.zero}, 32'd0);
        check("and.err", {31'd0, bus.err}, 32'd0);
        check("and.busy", {31'd0, bus.busy}, 32'd1);
        step();
        check("and.one_cycle", {31'd0, bus.out_valid}, 32'd0);
        check("and.in_ready", {31'd0, bus.in_ready}, 32'd1);
        bus.out_ready = 1'b0;

        // XOR / XNOR and the zero flag
        xact(3'd4, 8'hAA, 8'hAA, lat);
        check("xor.result", {24'd0, bus.result}, 32'h00);
        check("xor.zero", {31'd0, bus.zero}, 32'd1);
        finish_xact("xor");
        xact(3'd5, 8'hAA, 8'hAA, lat);
        check("xnor.result", {24'd0, bus.result}, 32'hFF);
        check("xnor.zero", {31'd0, bus.zero}, 32'd0);
        finish_xact("xnor");

        // NOR / NAND / OR
        xact(3'd2, 8'h0F, 8'h33, lat);
        check("nor.result", {24'd0, bus.result}, 32'hC0);
        finish_xact("nor");
        xact(3'd3, 8'h0F, 8'h33, lat);
        check("nand.result", {24'd0, bus.result}, 32'hFC);
        finish_xact("nand");
        xact(3'd1, 8'h0F, 8'h33, lat);
        check("or.latency", lat, 32'd9);
        check("or.result", {24'd0, bus.result}, 32'h3F);

        // Backpressure: hold DONE for 5 cycles, poke in_valid meanwhile
        for (int i = 0; i < 5; i++) begin
            check("bp.out_valid", {31'd0, bus.out_valid}, 32'd1);
            check("bp.result", {24'd0, bus.result}, 32'h3F);
            check("bp.zero", {31'd0, bus.zero}, 32'd0);
            check("bp.in_ready", {31'd0, bus.in_ready}, 32'd0);
            if (i == 1) begin
                bus.op       = 3'd0;
                bus.a        = 8'h00;
                bus.b        = 8'h00;
                bus.in_valid = 1'b1;
            end
            if (i == 3) bus.in_valid = 1'b0;
            step();
        end
        finish_xact("bp");
        step();
        check("bp.not_captured", {31'd0, bus.busy}, 32'd0);

        // Illegal opcode, then a legal one
        xact(3'd6, 8'hFF, 8'hFF, lat);
        check("ill.latency", lat, 32'd1);
        check("ill.result", {24'd0, bus.result}, 32'h00);
        check("ill.err", {31'd0, bus.err}, 32'd1);
        check("ill.zero", {31'd0, bus.zero}, 32'd0);
        finish_xact("ill");
        xact(3'd0, 8'hFF, 8'hFF, lat);
        check("ill_next.latency", lat, 32'd9);
        check("ill_next.result", {24'd0, bus.result}, 32'hFF);
        check("ill_next.err", {31'd0, bus.err}, 32'd0);
        finish_xact("ill_next");

        // Reset during the third SHIFT cycle
        bus.op       = 3'd0;
        bus.a        = 8'h3C;
        bus.b        = 8'hFF;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid.in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("mid.out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mid.result", {24'd0, bus.result}, 32'h00);
        check("mid.zero", {31'd0, bus.zero}, 32'd0);
        check("mid.err", {31'd0, bus.err}, 32'd0);
        check("mid.busy", {31'd0, bus.busy}, 32'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.out_valid) seen++;
        end
        check("mid.no_output", seen, 32'd0);
        xact(3'd0, 8'h5A, 8'hFF, lat);
        check("mid_next.latency", lat, 32'd9);
        check("mid_next.result", {24'd0, bus.result}, 32'h5A);
        finish_xact("mid_next");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
